// File: rtl/bridge_host_if.sv
// Host-side bus, response and UART byte signals of the ASCII bridge.
// slave = bridge_host, master = bus host plus UART endpoints.
interface bridge_host_if;
  logic [15:0] req_addr_i;
  logic [15:0] req_data_i;
  logic        req_rw_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] resp_data_o;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;

  modport slave (
    input  req_addr_i, req_data_i, req_rw_i, req_valid_i,
    input  tx_done_i, rx_data_i, rx_valid_i,
    output req_ready_o, resp_data_o, resp_valid_o, resp_err_o,
    output tx_data_o, tx_start_o
  );

  modport master (
    output req_addr_i, req_data_i, req_rw_i, req_valid_i,
    output tx_done_i, rx_data_i, rx_valid_i,
    input  req_ready_o, resp_data_o, resp_valid_o, resp_err_o,
    input  tx_data_o, tx_start_o
  );
endinterface

// File: rtl/bridge_host.sv
// Host end of the ASCII bridge: encodes R/W command frames and
// decodes "D" + 4 hex digit read replies, with a reply timeout.
module bridge_host #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic         clk,
  input logic         rst_n,
  bridge_host_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_D, DIGITS
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          rw_q, rw_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    dcnt_q, dcnt_d;
  logic [15:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [7:0]    txd_q, txd_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [4:0]    hv;
  logic          done;

  function automatic logic [7:0] hex_a(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // {valid, value} for an uppercase ASCII hex digit
  function automatic logic [4:0] hex_v(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic        rw,
    input logic [15:0] a,
    input logic [15:0] d,
    input logic [3:0]  i
  );
    logic [7:0] b;
    case (i)
      4'd0:    b = rw ? 8'h57 : 8'h52;
      4'd1:    b = hex_a(a[15:12]);
      4'd2:    b = hex_a(a[11:8]);
      4'd3:    b = hex_a(a[7:4]);
      4'd4:    b = hex_a(a[3:0]);
      4'd5:    b = rw ? hex_a(d[15:12]) : 8'h0D;
      4'd6:    b = rw ? hex_a(d[11:8]) : 8'h0A;
      4'd7:    b = hex_a(d[7:4]);
      4'd8:    b = hex_a(d[3:0]);
      4'd9:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign hv = hex_v(bus.rx_data_i);

  // next-state, frame sequencing, reply parsing and timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          data_d  = bus.req_data_i;
          rw_d    = bus.req_rw_i;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.tx_done_i) begin
          if (idx_q == (rw_q ? 4'd10 : 4'd6)) begin
            idx_d = 4'd0;
            if (rw_q) begin
              state_d = IDLE;
              rv_d    = 1'b1;
              err_d   = 1'b0;
              rdata_d = 16'h0;
            end else begin
              state_d = WAIT_D;
              cnt_d   = '0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_D, DIGITS: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.rx_valid_i) begin
          if (state_q == WAIT_D) begin
            if (bus.rx_data_i == 8'h44) begin
              state_d = DIGITS;
              dcnt_d  = 3'd0;
              acc_d   = 16'h0;
            end
          end else if (dcnt_q != 3'd4) begin
            if (hv[4]) begin
              acc_d  = {acc_q[11:0], hv[3:0]};
              dcnt_d = dcnt_q + 3'd1;
            end else begin
              state_d = WAIT_D;
              acc_d   = 16'h0;
            end
          end else if (bus.rx_data_i == 8'h0D ||
                       bus.rx_data_i == 8'h0A) begin
            done = 1'b1;
          end else begin
            state_d = WAIT_D;
            acc_d   = 16'h0;
          end
        end
        // a terminator in the expiry cycle still delivers the data
        if (done) begin
          state_d = IDLE;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          rdata_d = acc_q;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = 16'h0;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == SEND);
    txd_d   = start_d ? frame_byte(rw_d, addr_d, data_d, idx_d) : 8'h0;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 16'h0;
      data_q  <= 16'h0;
      rw_q    <= 1'b0;
      idx_q   <= 4'd0;
      dcnt_q  <= 3'd0;
      acc_q   <= 16'h0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      txd_q   <= 8'h0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      txd_q   <= txd_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.tx_start_o   = start_q;
  assign bus.tx_data_o    = txd_q;
  assign bus.resp_valid_o = rv_q;
  assign bus.resp_err_o   = err_q;
  assign bus.resp_data_o  = rdata_q;

endmodule
